// File: rtl/median3x3_seq_if.sv
// Column-in / pixel-out handshake bundle for the 3x3 pseudo-median sequencer.
// The slave side is the sequencer; the master side is whoever feeds it columns and drains results.
interface median3x3_seq_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] col_top;
  logic [WIDTH-1:0] col_mid;
  logic [WIDTH-1:0] col_bot;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_pix;

  modport master (
    output in_valid, col_top, col_mid, col_bot, out_ready,
    input  in_ready, out_valid, out_pix
  );

  modport slave (
    input  in_valid, col_top, col_mid, col_bot, out_ready,
    output in_ready, out_valid, out_pix
  );
endinterface

// File: rtl/median3x3_seq.sv
// 3x3 pseudo-median (median of column medians) computed by time-sharing one 3-input median unit.
// Columns load over three handshakes, then three column medians and one final median are formed.
module median (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [7:0] c,
  output logic [7:0] m
);
  logic [7:0] lo;
  logic [7:0] hi;
  logic [7:0] hic;

  // median(a,b,c) = max(min(a,b), min(max(a,b), c))
  always_comb begin
    lo  = (a < b) ? a : b;
    hi  = (a < b) ? b : a;
    hic = (hi < c) ? hi : c;
    m   = (lo > hic) ? lo : hic;
  end
endmodule

module median3x3_seq #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  median3x3_seq_if.slave       bus,
  output logic                 busy,
  output logic [15:0]          win_cnt
);
  typedef enum logic [1:0] {LOAD, COLMED, FINAL, OUT} state_t;

  state_t           state;
  logic [WIDTH-1:0] win [3][3];
  logic [WIDTH-1:0] med [3];
  logic [1:0]       col_cnt;
  logic [1:0]       k;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] out_pix_q;
  logic [WIDTH-1:0] mux_top;
  logic [WIDTH-1:0] mux_mid;
  logic [WIDTH-1:0] mux_bot;
  logic [WIDTH-1:0] m;

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_pix   = out_pix_q;

  // Shared median operand select: stored column k while sorting columns, column medians in FINAL.
  always_comb begin
    mux_top = win[k][0];
    mux_mid = win[k][1];
    mux_bot = win[k][2];
    if (state == FINAL) begin
      mux_top = med[0];
      mux_mid = med[1];
      mux_bot = med[2];
    end
  end

  median u_median (
    .a(mux_top),
    .b(mux_mid),
    .c(mux_bot),
    .m(m)
  );

  // Handshake outputs and busy are registered alongside the state so they never see in_valid/out_ready combinationally.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= LOAD;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_pix_q   <= '0;
      busy        <= 1'b0;
      win_cnt     <= 16'd0;
      col_cnt     <= 2'd0;
      k           <= 2'd0;
      for (int c = 0; c < 3; c++) begin
        med[c] <= '0;
        for (int r = 0; r < 3; r++) begin
          win[c][r] <= '0;
        end
      end
    end else begin
      case (state)
        LOAD: begin
          if (bus.in_valid && in_ready_q) begin
            win[col_cnt][0] <= bus.col_top;
            win[col_cnt][1] <= bus.col_mid;
            win[col_cnt][2] <= bus.col_bot;
            busy            <= 1'b1;
            if (col_cnt == 2'd2) begin
              col_cnt    <= 2'd0;
              k          <= 2'd0;
              in_ready_q <= 1'b0;
              state      <= COLMED;
            end else begin
              col_cnt <= col_cnt + 2'd1;
            end
          end
        end
        COLMED: begin
          med[k] <= m;
          if (k == 2'd2) begin
            k     <= 2'd0;
            state <= FINAL;
          end else begin
            k <= k + 2'd1;
          end
        end
        FINAL: begin
          out_pix_q   <= m;
          out_valid_q <= 1'b1;
          state       <= OUT;
        end
        OUT: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy        <= 1'b0;
            win_cnt     <= win_cnt + 16'd1;
            state       <= LOAD;
          end
        end
        default: begin
          state <= LOAD;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_median3x3_seq.sv
// Directed bench for median3x3_seq: reset, latency, pseudo-median values, backpressure,
// back-to-back streaming and reset in the middle of a computation.
module tb_median3x3_seq;
  logic        clk;
  logic        rst;
  logic        busy;
  logic [15:0] win_cnt;
  int          total;
  int          bad;

  median3x3_seq_if #(.WIDTH(8)) bus ();

  median3x3_seq #(.WIDTH(8)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave),
    .busy(busy),
    .win_cnt(win_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Streaming table: windows (1..9)->5, (12,32,128 rotated)->32, (0/255)->0, mixed->61.
  logic [7:0] tops [12] = '{8'd1, 8'd4, 8'd7, 8'd12, 8'd32, 8'd128, 8'd0, 8'd0, 8'd0, 8'd9, 8'd100, 8'd60};
  logic [7:0] mids [12] = '{8'd2, 8'd5, 8'd8, 8'd32, 8'd128, 8'd12, 8'd0, 8'd255, 8'd0, 8'd200, 8'd3, 8'd61};
  logic [7:0] bots [12] = '{8'd3, 8'd6, 8'd9, 8'd128, 8'd12, 8'd32, 8'd255, 8'd255, 8'd255, 8'd50, 8'd77, 8'd62};
  logic [7:0] expRes [4] = '{8'd5, 8'd32, 8'd0, 8'd61};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] t, input logic [7:0] m, input logic [7:0] b);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.col_top  = t;
    bus.col_mid  = m;
    bus.col_bot  = b;
    while (bus.in_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) checkOutput("in_ready_timeout", {31'd0, bus.in_ready}, 32'd1);
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic pushWindow(input int base);
    for (int c = 0; c < 3; c++) applyStimulus(tops[base+c], mids[base+c], bots[base+c]);
  endtask

  task automatic waitOutValid(output int lat);
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic doReset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int   lat;
    int   idx;
    int   nres;
    int   cyc;
    int   lastCyc;
    logic rdy;
    logic sawValid;
    total         = 0;
    bad           = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.col_top   = 8'd0;
    bus.col_mid   = 8'd0;
    bus.col_bot   = 8'd0;
    bus.out_ready = 1'b1;

    doReset();
    checkOutput("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    checkOutput("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    checkOutput("rst_out_pix", {24'd0, bus.out_pix}, 32'd0);
    checkOutput("rst_win_cnt", {16'd0, win_cnt}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);

    // Basic window, result 32 four edges after the third accept.
    applyStimulus(8'd12, 8'd32, 8'd128);
    checkOutput("basic_busy_partial", {31'd0, busy}, 32'd1);
    applyStimulus(8'd32, 8'd128, 8'd12);
    applyStimulus(8'd128, 8'd12, 8'd32);
    checkOutput("basic_in_ready_low", {31'd0, bus.in_ready}, 32'd0);
    waitOutValid(lat);
    checkOutput("basic_latency", lat, 32'd4);
    checkOutput("basic_pix", {24'd0, bus.out_pix}, 32'd32);
    tick();
    checkOutput("basic_consumed", {31'd0, bus.out_valid}, 32'd0);
    checkOutput("basic_win_cnt", {16'd0, win_cnt}, 32'd1);
    checkOutput("basic_in_ready_back", {31'd0, bus.in_ready}, 32'd1);
    checkOutput("basic_busy_idle", {31'd0, busy}, 32'd0);

    // Backpressure on the (1..9) window with in_valid pulses that must be ignored.
    bus.out_ready = 1'b0;
    pushWindow(0);
    waitOutValid(lat);
    checkOutput("bp_latency", lat, 32'd4);
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = i[0];
      bus.col_top  = 8'(i + 40);
      bus.col_mid  = 8'(i + 41);
      bus.col_bot  = 8'(i + 42);
      tick();
      checkOutput("bp_pix_hold", {24'd0, bus.out_pix}, 32'd5);
      checkOutput("bp_valid_hold", {31'd0, bus.out_valid}, 32'd1);
      checkOutput("bp_in_ready_low", {31'd0, bus.in_ready}, 32'd0);
    end
    checkOutput("bp_win_cnt_held", {16'd0, win_cnt}, 32'd1);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    checkOutput("bp_win_cnt_once", {16'd0, win_cnt}, 32'd2);
    checkOutput("bp_no_column_taken", {31'd0, busy}, 32'd0);
    tick();
    checkOutput("bp_win_cnt_stable", {16'd0, win_cnt}, 32'd2);

    // Per-column sorting: column medians 0,255,0 -> 0.
    pushWindow(6);
    waitOutValid(lat);
    checkOutput("sort_pix", {24'd0, bus.out_pix}, 32'd0);
    tick();
    checkOutput("sort_win_cnt", {16'd0, win_cnt}, 32'd3);

    // Back-to-back: four windows streamed with in_valid held high.
    doReset();
    bus.out_ready = 1'b1;
    idx     = 0;
    nres    = 0;
    cyc     = 0;
    lastCyc = 0;
    while (nres < 4 && cyc < 200) begin
      if (idx < 12) begin
        bus.in_valid = 1'b1;
        bus.col_top  = tops[idx];
        bus.col_mid  = mids[idx];
        bus.col_bot  = bots[idx];
      end else begin
        bus.in_valid = 1'b0;
      end
      rdy = bus.in_ready;
      tick();
      cyc++;
      if (rdy && idx < 12) idx++;
      if (bus.out_valid === 1'b1) begin
        checkOutput("b2b_pix", {24'd0, bus.out_pix}, {24'd0, expRes[nres]});
        if (nres > 0) checkOutput("b2b_spacing", cyc - lastCyc, 32'd8);
        lastCyc = cyc;
        nres++;
      end
    end
    bus.in_valid = 1'b0;
    checkOutput("b2b_count", nres, 32'd4);
    tick();
    checkOutput("b2b_win_cnt", {16'd0, win_cnt}, 32'd4);

    // Reset while COLMED is on k=1: result dropped, then a fresh window still works.
    doReset();
    pushWindow(0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("mid_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    checkOutput("mid_rst_busy", {31'd0, busy}, 32'd0);
    sawValid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      sawValid = sawValid | bus.out_valid;
      tick();
    end
    checkOutput("mid_rst_no_valid", {31'd0, sawValid}, 32'd0);
    checkOutput("mid_rst_win_cnt", {16'd0, win_cnt}, 32'd0);
    pushWindow(9);
    waitOutValid(lat);
    checkOutput("mid_rst_latency", lat, 32'd4);
    checkOutput("mid_rst_pix", {24'd0, bus.out_pix}, 32'd61);
    tick();
    checkOutput("mid_rst_win_cnt_after", {16'd0, win_cnt}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
